// File: rtl/mem_burst_pkg.sv
// Shared AXI constants, FSM state encoding and clog2 helper for the burst-read responder.
package mem_burst_pkg;

  localparam logic [1:0]  AXI_BURST_INCR = 2'b01;
  localparam logic [1:0]  AXI_RESP_OKAY  = 2'b00;
  localparam int unsigned AXI_4K_BYTES   = 4096;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CALC,
    ST_AR,
    ST_DATA,
    ST_DONE
  } state_e;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mem_burst_split.sv
// Combinational sizing of the next AXI transaction: min(remaining, MAX_BEATS, beats to 4 KB boundary).
module mem_burst_split
  import mem_burst_pkg::*;
#(
  parameter int unsigned MEM_DATA_BITS = 64,
  parameter int unsigned ADDR_BITS     = 27,
  parameter int unsigned AXI_ADDR_BITS = 32,
  parameter int unsigned MAX_BEATS     = 256
) (
  input  logic [ADDR_BITS-1:0]     waddr_i,
  input  logic [9:0]               rem_i,
  output logic [AXI_ADDR_BITS-1:0] byte_addr_o,
  output logic [8:0]               sub_o
);

  localparam int unsigned LB = clog2(MEM_DATA_BITS / 8);

  logic [ADDR_BITS+LB-1:0] word_bytes;
  logic [12:0]             to4k;
  logic [12:0]             lim;

  assign word_bytes  = {waddr_i, LB'(0)};
  assign byte_addr_o = AXI_ADDR_BITS'(word_bytes);
  assign to4k        = (13'(AXI_4K_BYTES) - {1'b0, byte_addr_o[11:0]}) >> LB;

  always_comb begin
    lim = 13'(MAX_BEATS);
    if (to4k < lim) lim = to4k;
    if ({3'b000, rem_i} < lim) lim = {3'b000, rem_i};
    sub_o = lim[8:0];
  end

endmodule

// File: rtl/mem_burst_rd_axi.sv
// Burst-read responder: turns rd_burst requests into split AXI4 read transactions.
// Optional rresp error tracking (rd_err / rd_err_cnt) is enabled by MEM_RD_RESP_CHK_EN.
module mem_burst_rd_axi
  import mem_burst_pkg::*;
#(
  parameter int unsigned MEM_DATA_BITS = 64,
  parameter int unsigned ADDR_BITS     = 27,
  parameter int unsigned AXI_ADDR_BITS = 32,
  parameter int unsigned MAX_BEATS     = 256
) (
  input  logic                     mem_clk,
  input  logic                     rst_n,
  input  logic                     rd_burst_req,
  input  logic [9:0]               rd_burst_len,
  input  logic [ADDR_BITS-1:0]     rd_burst_addr,
  output logic                     rd_burst_data_valid,
  output logic [MEM_DATA_BITS-1:0] rd_burst_data,
  output logic                     rd_burst_finish,
  output logic                     busy,
`ifdef MEM_RD_RESP_CHK_EN
  output logic                     rd_err,
  output logic [15:0]              rd_err_cnt,
`endif
  output logic [AXI_ADDR_BITS-1:0] m_axi_araddr,
  output logic [7:0]               m_axi_arlen,
  output logic [2:0]               m_axi_arsize,
  output logic [1:0]               m_axi_arburst,
  output logic                     m_axi_arvalid,
  input  logic                     m_axi_arready,
  input  logic [MEM_DATA_BITS-1:0] m_axi_rdata,
  input  logic [1:0]               m_axi_rresp,
  input  logic                     m_axi_rlast,
  input  logic                     m_axi_rvalid,
  output logic                     m_axi_rready
);

  localparam int unsigned LB = clog2(MEM_DATA_BITS / 8);

  state_e                   state_q, state_d;
  logic [9:0]               rem_q, rem_d;
  logic [ADDR_BITS-1:0]     waddr_q, waddr_d;
  logic [AXI_ADDR_BITS-1:0] araddr_q, araddr_d;
  logic [7:0]               arlen_q, arlen_d;
  logic                     arvalid_q, finish_q, busy_q;
  logic [AXI_ADDR_BITS-1:0] calc_addr;
  logic [8:0]               calc_sub;
  logic [8:0]               cur_beats;
  logic                     r_hs;

  mem_burst_split #(
    .MEM_DATA_BITS(MEM_DATA_BITS),
    .ADDR_BITS    (ADDR_BITS),
    .AXI_ADDR_BITS(AXI_ADDR_BITS),
    .MAX_BEATS    (MAX_BEATS)
  ) u_split (
    .waddr_i    (waddr_q),
    .rem_i      (rem_q),
    .byte_addr_o(calc_addr),
    .sub_o      (calc_sub)
  );

  // Beats of the in-flight transaction are recovered from arlen rather than kept separately.
  assign cur_beats = 9'(arlen_q) + 9'd1;
  assign r_hs      = m_axi_rvalid & m_axi_rready;

  always_comb begin
    state_d      = state_q;
    rem_d        = rem_q;
    waddr_d      = waddr_q;
    araddr_d     = araddr_q;
    arlen_d      = arlen_q;
    m_axi_rready = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rd_burst_req && (rd_burst_len != 10'd0)) begin
          rem_d   = rd_burst_len;
          waddr_d = rd_burst_addr;
          state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        araddr_d = calc_addr;
        arlen_d  = 8'(calc_sub - 9'd1);
        state_d  = ST_AR;
      end
      ST_AR: begin
        if (m_axi_arready) begin
          rem_d   = rem_q - 10'(cur_beats);
          waddr_d = waddr_q + ADDR_BITS'(cur_beats);
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        m_axi_rready = 1'b1;
        if (m_axi_rvalid && m_axi_rlast) begin
          state_d = (rem_q == 10'd0) ? ST_DONE : ST_CALC;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge mem_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      rem_q     <= '0;
      waddr_q   <= '0;
      araddr_q  <= '0;
      arlen_q   <= '0;
      arvalid_q <= 1'b0;
      finish_q  <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      waddr_q   <= waddr_d;
      araddr_q  <= araddr_d;
      arlen_q   <= arlen_d;
      arvalid_q <= (state_d == ST_AR);
      finish_q  <= (state_d == ST_DONE);
      busy_q    <= (state_d != ST_IDLE);
    end
  end

  assign m_axi_araddr        = araddr_q;
  assign m_axi_arlen         = arlen_q;
  assign m_axi_arsize        = 3'(LB);
  assign m_axi_arburst       = AXI_BURST_INCR;
  assign m_axi_arvalid       = arvalid_q;
  assign rd_burst_data_valid = r_hs;
  assign rd_burst_data       = r_hs ? m_axi_rdata : '0;
  assign rd_burst_finish     = finish_q;
  assign busy                = busy_q;

`ifdef MEM_RD_RESP_CHK_EN
  logic        rd_err_q;
  logic [15:0] rd_err_cnt_q;

  always_ff @(posedge mem_clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_err_q     <= 1'b0;
      rd_err_cnt_q <= '0;
    end else if (r_hs && (m_axi_rresp != AXI_RESP_OKAY)) begin
      rd_err_q <= 1'b1;
      if (rd_err_cnt_q != '1) rd_err_cnt_q <= rd_err_cnt_q + 16'd1;
    end
  end

  assign rd_err     = rd_err_q;
  assign rd_err_cnt = rd_err_cnt_q;
`else
  logic unused_rresp;
  assign unused_rresp = ^m_axi_rresp;
`endif

endmodule

// File: tb/tb_mem_burst_rd_axi.sv
// Randomised scoreboard bench for mem_burst_rd_axi with a behavioural AXI slave and split model.
module tb_mem_burst_rd_axi;

  logic        mem_clk = 1'b0;
  logic        rst_n;
  logic        rd_burst_req;
  logic [9:0]  rd_burst_len;
  logic [26:0] rd_burst_addr;
  logic        rd_burst_data_valid;
  logic [63:0] rd_burst_data;
  logic        rd_burst_finish;
  logic        busy;
`ifdef MEM_RD_RESP_CHK_EN
  logic        rd_err;
  logic [15:0] rd_err_cnt;
`endif
  logic [31:0] m_axi_araddr;
  logic [7:0]  m_axi_arlen;
  logic [2:0]  m_axi_arsize;
  logic [1:0]  m_axi_arburst;
  logic        m_axi_arvalid;
  logic        m_axi_arready;
  logic [63:0] m_axi_rdata;
  logic [1:0]  m_axi_rresp;
  logic        m_axi_rlast;
  logic        m_axi_rvalid;
  logic        m_axi_rready;

  always #5 mem_clk = ~mem_clk;

  mem_burst_rd_axi #(
    .MEM_DATA_BITS(64),
    .ADDR_BITS    (27),
    .AXI_ADDR_BITS(32),
    .MAX_BEATS    (256)
  ) dut (
    .mem_clk            (mem_clk),
    .rst_n              (rst_n),
    .rd_burst_req       (rd_burst_req),
    .rd_burst_len       (rd_burst_len),
    .rd_burst_addr      (rd_burst_addr),
    .rd_burst_data_valid(rd_burst_data_valid),
    .rd_burst_data      (rd_burst_data),
    .rd_burst_finish    (rd_burst_finish),
    .busy               (busy),
`ifdef MEM_RD_RESP_CHK_EN
    .rd_err             (rd_err),
    .rd_err_cnt         (rd_err_cnt),
`endif
    .m_axi_araddr       (m_axi_araddr),
    .m_axi_arlen        (m_axi_arlen),
    .m_axi_arsize       (m_axi_arsize),
    .m_axi_arburst      (m_axi_arburst),
    .m_axi_arvalid      (m_axi_arvalid),
    .m_axi_arready      (m_axi_arready),
    .m_axi_rdata        (m_axi_rdata),
    .m_axi_rresp        (m_axi_rresp),
    .m_axi_rlast        (m_axi_rlast),
    .m_axi_rvalid       (m_axi_rvalid),
    .m_axi_rready       (m_axi_rready)
  );

  int checks = 0;
  int passes = 0;

  logic [39:0] exp_ar[$];
  logic [63:0] exp_data[$];
  int          exp_len[$];

  int ar_mode = 0;
  int r_mode = 0;
  bit err_inject = 1'b0;
  int finish_cnt = 0;
  int cur_beats = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  task automatic fail_now(input string nm);
    checks++;
    $display("FAIL %s: bound expired or unexpected event at %0t", nm, $time);
  endtask

  // Reference: walk the burst, cutting each piece at 256 beats and at the next 4 KB boundary.
  task automatic model_push(input int len, input logic [26:0] addr);
    longint unsigned a, byte_a, to4k;
    int rem, sub;
    a = addr;
    rem = len;
    while (rem > 0) begin
      byte_a = a * 8;
      to4k = (4096 - (byte_a % 4096)) / 8;
      sub = rem;
      if (sub > 256) sub = 256;
      if (longint'(sub) > longint'(to4k)) sub = int'(to4k);
      exp_ar.push_back({32'(byte_a), 8'(sub - 1)});
      a = (a + longint'(sub)) % (64'd1 << 27);
      rem -= sub;
    end
    exp_len.push_back(len);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_arvalid"}, m_axi_arvalid, 0);
    chk({tag, "_rready"}, m_axi_rready, 0);
    chk({tag, "_finish"}, rd_burst_finish, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_araddr"}, m_axi_araddr, 0);
    chk({tag, "_arlen"}, m_axi_arlen, 0);
    chk({tag, "_dvalid"}, rd_burst_data_valid, 0);
    chk({tag, "_data"}, rd_burst_data, 0);
`ifdef MEM_RD_RESP_CHK_EN
    chk({tag, "_rd_err"}, rd_err, 0);
    chk({tag, "_rd_err_cnt"}, rd_err_cnt, 0);
`endif
  endtask

  task automatic wait_first_beat(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 3000 && !ok; c++) begin
      @(negedge mem_clk);
      if (rd_burst_data_valid) ok = 1'b1;
    end
    if (!ok) fail_now("first_beat_timeout");
  endtask

  task automatic run_burst(input int len, input logic [26:0] addr, input int am, input int rm);
    int f0;
    bit ok;
    ar_mode = am;
    r_mode = rm;
    model_push(len, addr);
    f0 = finish_cnt;
    @(posedge mem_clk); #1;
    rd_burst_req  = 1'b1;
    rd_burst_len  = 10'(len);
    rd_burst_addr = addr;
    wait_first_beat(ok);
    @(posedge mem_clk); #1;
    rd_burst_req  = 1'b0;
    rd_burst_len  = 10'($urandom);
    rd_burst_addr = 27'($urandom);
    ok = 1'b0;
    for (int c = 0; c < 20000 && !ok; c++) begin
      @(negedge mem_clk);
      if (finish_cnt != f0) ok = 1'b1;
    end
    if (!ok) fail_now("finish_timeout");
  endtask

  // Monitor: compares every DUT output cycle against the scoreboard queues.
  initial begin : monitor
    bit ar_prev, prev_dv, prev_fin;
    logic [31:0] cap_addr;
    logic [7:0] cap_len;
    logic [39:0] e;
    logic [63:0] d;
    ar_prev = 0; prev_dv = 0; prev_fin = 0;
    cap_addr = '0; cap_len = '0;
    forever begin
      @(negedge mem_clk);
      if (!rst_n) begin
        ar_prev = 0; prev_dv = 0; prev_fin = 0; cur_beats = 0;
      end else begin
        if (m_axi_arvalid) begin
          if (!ar_prev) begin
            if (exp_ar.size() == 0) begin
              fail_now("ar_unexpected");
            end else begin
              e = exp_ar.pop_front();
              chk("araddr", m_axi_araddr, e[39:8]);
              chk("arlen", m_axi_arlen, e[7:0]);
              chk("arsize", m_axi_arsize, 3);
              chk("arburst", m_axi_arburst, 1);
              cap_addr = m_axi_araddr;
              cap_len = m_axi_arlen;
            end
          end else begin
            chk("araddr_stable", m_axi_araddr, cap_addr);
            chk("arlen_stable", m_axi_arlen, cap_len);
          end
        end
        ar_prev = m_axi_arvalid;
        chk("dvalid_vs_rvalid", rd_burst_data_valid, m_axi_rvalid);
        if (rd_burst_data_valid) begin
          if (exp_data.size() == 0) fail_now("data_unexpected");
          else begin
            d = exp_data.pop_front();
            chk("rd_data", rd_burst_data, d);
          end
          cur_beats++;
        end else begin
          chk("data_zero_idle", rd_burst_data, 0);
        end
        if (rd_burst_finish) begin
          chk("finish_after_last_beat", prev_dv, 1);
          chk("busy_at_finish", busy, 1);
          if (exp_len.size() == 0) fail_now("finish_unexpected");
          else chk("beat_count", cur_beats, exp_len.pop_front());
          cur_beats = 0;
          finish_cnt++;
        end else if (prev_fin) begin
          chk("busy_after_finish", busy, 0);
        end
        prev_dv = rd_burst_data_valid;
        prev_fin = rd_burst_finish;
      end
    end
  end

  // AXI slave: AR acceptance policy per ar_mode, R beats with gaps per r_mode.
  initial begin : slave
    int n, arv_cnt, waited;
    bit aborted;
    m_axi_arready = 0; m_axi_rvalid = 0; m_axi_rlast = 0;
    m_axi_rdata = '0; m_axi_rresp = 2'b00;
    arv_cnt = 0;
    forever begin
      @(negedge mem_clk);
      if (rst_n && m_axi_arvalid && m_axi_arready) begin
        n = int'(m_axi_arlen) + 1;
        arv_cnt = 0;
        aborted = 0;
        @(posedge mem_clk); #1;
        m_axi_arready = 0;
        for (int b = 0; b < n && !aborted; b++) begin
          if ((r_mode == 2 && b > 0) || (r_mode == 1 && $urandom_range(0, 2) == 0)) begin
            m_axi_rvalid = 0; m_axi_rlast = 0;
            @(posedge mem_clk); #1;
          end
          m_axi_rvalid = 1;
          m_axi_rdata = {$urandom, $urandom};
          m_axi_rlast = (b == n - 1);
          m_axi_rresp = (err_inject && b == 3) ? 2'b10 : 2'b00;
          exp_data.push_back(m_axi_rdata);
          waited = 0;
          do begin
            @(negedge mem_clk);
            waited++;
            if (!rst_n) aborted = 1;
          end while (!aborted && !m_axi_rready && waited < 100);
          if (!aborted && !m_axi_rready) begin
            fail_now("rready_timeout");
            aborted = 1;
          end
          if (!aborted) begin
            @(posedge mem_clk); #1;
          end
          m_axi_rvalid = 0; m_axi_rlast = 0; m_axi_rresp = 2'b00;
        end
      end else begin
        if (m_axi_arvalid) arv_cnt++;
        else arv_cnt = 0;
        @(posedge mem_clk); #1;
        case (ar_mode)
          0: m_axi_arready = 1;
          1: m_axi_arready = 1'($urandom_range(0, 1));
          default: m_axi_arready = (arv_cnt >= 20);
        endcase
      end
    end
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    bit ok;
    int len;
    logic [26:0] addr;
    rst_n = 0;
    rd_burst_req = 0;
    rd_burst_len = '0;
    rd_burst_addr = '0;
    repeat (3) @(posedge mem_clk);
    @(negedge mem_clk);
    check_reset_outputs("reset");
    @(posedge mem_clk); #3;
    rst_n = 1;

    run_burst(16, 27'd0, 0, 0);
    run_burst(600, 27'd0, 0, 0);
    run_burst(20, 27'd500, 0, 0);

    @(posedge mem_clk); #1;
    rd_burst_req = 1; rd_burst_len = 10'd0; rd_burst_addr = 27'd5;
    repeat (10) begin
      @(negedge mem_clk);
      chk("zero_len_arvalid", m_axi_arvalid, 0);
      chk("zero_len_finish", rd_burst_finish, 0);
      chk("zero_len_busy", busy, 0);
    end
    @(posedge mem_clk); #1;
    rd_burst_req = 0;

    run_burst(40, 27'd1000, 2, 2);

    ar_mode = 0; r_mode = 0;
    model_push(64, 27'd2048);
    @(posedge mem_clk); #1;
    rd_burst_req = 1; rd_burst_len = 10'd64; rd_burst_addr = 27'd2048;
    wait_first_beat(ok);
    @(posedge mem_clk); #1;
    rd_burst_req = 0;
    ok = 0;
    for (int c = 0; c < 500 && !ok; c++) begin
      @(negedge mem_clk);
      if (cur_beats >= 5) ok = 1;
    end
    if (!ok) fail_now("mid_burst_progress_timeout");
    #2;
    rst_n = 0;
    #1;
    check_reset_outputs("async_reset");
    repeat (3) @(posedge mem_clk);
    exp_ar.delete();
    exp_data.delete();
    exp_len.delete();
    @(posedge mem_clk); #3;
    rst_n = 1;

    err_inject = 1;
    run_burst(8, 27'd64, 0, 0);
    err_inject = 0;
`ifdef MEM_RD_RESP_CHK_EN
    chk("rd_err_after_slverr", rd_err, 1);
    chk("rd_err_cnt_after_slverr", rd_err_cnt, 1);
`endif

    run_burst(20, 27'h7FFFFFA, 1, 1);

    for (int i = 0; i < 10; i++) begin
      len = (i < 3) ? int'($urandom_range(1, 1023)) : int'($urandom_range(1, 200));
      addr = 27'($urandom);
      if ($urandom_range(0, 1) == 1) addr = (addr & 27'h7FFFE00) | 27'($urandom_range(9'h1E0, 9'h1FF));
      run_burst(len, addr, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
    end

    repeat (3) @(negedge mem_clk);
    chk("ar_queue_drained", exp_ar.size(), 0);
    chk("data_queue_drained", exp_data.size(), 0);
    chk("burst_queue_drained", exp_len.size(), 0);
    chk("idle_busy", busy, 0);
`ifdef MEM_RD_RESP_CHK_EN
    chk("rd_err_sticky", rd_err, 1);
    chk("rd_err_cnt_final", rd_err_cnt, 1);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
